param_stack: RTL
================

Name: param_stack

Overview:
- Parametrised successor to the CPU's fixed hardware stack.
- It is the call/return and data stack, connected to the CPU general data bus and driven by the control unit.
- New relative to the current stack:
  - configurable width and depth;
  - registered top-of-stack output;
  - atomic replace (push+pop in the same cycle);
  - selectable saturate or circular-overwrite overflow mode;
  - sticky overflow/underflow error flags.

Parameters:
- DATA_W, 14, entry width in bits (matches CPU data bus).
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- WRAP_MODE, 0, overflow policy: 0 = saturate (push when full is dropped); 1 = circular (push when full overwrites the oldest entry).
- PTR_W, $clog2(DEPTH), derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  push din this cycle.
- pop  in  1  pop the top entry this cycle.
- din  in  DATA_W  data to push.
- clr_err  in  1  clear the sticky error flags.
- dout  out  DATA_W  registered top-of-stack; 0 when empty.
- count  out  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; a push occurred while full.
- underflow  out  1  sticky; a pop occurred while empty.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk; the ports are named clk and reset.
- Reset values: count=0, dout=0, overflow=0, underflow=0, internal top pointer tp=0. Storage array is not reset.
- Reset has priority over all other inputs. Reset mid-operation discards the stack contents logically (count=0).
- Internal state:
  - tp, PTR_W bits, indexes the next free slot, modulo DEPTH.
  - Top entry is mem[tp-1]; all pointer arithmetic wraps modulo DEPTH.
- Every operation completes in one cycle. dout, count and the flags reflect the operation on the clock edge that performs it. No stall; no handshake.
- push only, not full: mem[tp]<=din; tp<=tp+1; count+1; dout<=din.
- push only, full:
  - WRAP_MODE=0: storage, tp and count unchanged; dout unchanged; overflow<=1.
  - WRAP_MODE=1: mem[tp]<=din; tp<=tp+1; count stays DEPTH (the oldest entry is lost); dout<=din; overflow<=1.
- pop only:
  - count>=2: tp<=tp-1; count-1; dout<=mem[tp-2].
  - count==1: tp<=tp-1; count<=0; dout<=0.
  - count==0: no state change; dout stays 0; underflow<=1.
- push and pop together:
  - count>=1: replace top. mem[tp-1]<=din; dout<=din; tp and count unchanged; no flag set (including when full).
  - count==0: behaves as push only; underflow is not set.
- Neither push nor pop: hold all state.
- clr_err clears overflow and underflow. If a new error event occurs in the same cycle, the set wins.
- empty and full are combinational decodes of the count register.
- Writes and the registered read use mem contents from before the edge. There is no write-through hazard, because dout is loaded from din directly on push and replace.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W default (14) and ADDR_W default (12), shared with the CPU top;
  - a localparam encoding for the control-unit stack op {NOP, PUSH, POP, REPLACE}, which the control unit decodes to push/pop.
- No sub-module is required. Storage, pointer and flag logic are a single module.
- Optional: a pointer helper stack_ptr_ctrl, containing tp/count next-state logic only. It is reusable for a future return-address stack.

Test Plan:
- Reset then idle 3 cycles: dout=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- DEPTH=4, WRAP_MODE=0. Push 0x001, 0x002, 0x003, 0x004: count=4, full=1, dout=0x004. Push 0x3FFF: dout stays 0x004, overflow=1. Pop x4: dout sequence 0x003, 0x002, 0x001, 0; empty=1.
- DEPTH=4, WRAP_MODE=1. Push 0x011..0x015: count=4, overflow=1, dout=0x015. Pop x4: dout sequence 0x014, 0x013, 0x012, 0; 0x011 has been lost.
- Pop on empty: underflow=1, count stays 0. Assert clr_err together with a second empty pop: underflow stays 1. Then clr_err alone: underflow=0.
- Stack holds 0x0AA, 0x0BB. Push+pop with din=0x1CD: dout=0x1CD, count=2. Pop: dout=0x0AA. Push+pop on empty with din=0x005: count=1, dout=0x005, underflow=0.
- Push 0x007, 0x008, then assert reset concurrently with push: count=0, dout=0. Next push 0x009, then pop: dout=0, empty=1 (no stale data is exposed).

Source files
------------

// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU top, the control unit and the parametrised stack.
package cpu_pkg;

  localparam int CPU_DATA_W = 14;
  localparam int CPU_ADDR_W = 12;

  // Stack operation issued by the control unit
  typedef enum logic [1:0] {
    STK_NOP     = 2'b00,
    STK_PUSH    = 2'b01,
    STK_POP     = 2'b10,
    STK_REPLACE = 2'b11
  } stk_op_e;

  // Action resolved by the pointer controller for the current cycle
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_PUSH,
    ACT_PUSH_FULL,
    ACT_POP,
    ACT_POP_EMPTY,
    ACT_REPLACE
  } stk_act_e;

  // Returns {push, pop} for a control-unit stack op
  function automatic logic [1:0] stk_op_decode(input stk_op_e op);
    case (op)
      STK_PUSH:    return 2'b10;
      STK_POP:     return 2'b01;
      STK_REPLACE: return 2'b11;
      default:     return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/stack_ptr_ctrl.sv
// Next-state logic for the stack top pointer and entry count; purely combinational
// so it can be reused by a return-address stack.
module stack_ptr_ctrl
  import cpu_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WRAP_MODE = 0,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0] i_tp,
  input  logic [PTR_W:0]   i_count,
  input  logic             i_push,
  input  logic             i_pop,
  output stk_act_e         o_act,
  output logic [PTR_W-1:0] o_tp_next,
  output logic [PTR_W:0]   o_count_next
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic w_empty;
  logic w_full;

  assign w_empty = (i_count == '0);
  assign w_full  = (i_count == CNT_FULL);

  always_comb begin
    o_act        = ACT_HOLD;
    o_tp_next    = i_tp;
    o_count_next = i_count;
    if (i_push) begin
      // push+pop on an empty stack degenerates to a plain push
      if (i_pop && !w_empty) begin
        o_act = ACT_REPLACE;
      end else if (!w_full) begin
        o_act        = ACT_PUSH;
        o_tp_next    = i_tp + PTR_W'(1);
        o_count_next = i_count + (PTR_W+1)'(1);
      end else begin
        o_act = ACT_PUSH_FULL;
        if (WRAP_MODE != 0) o_tp_next = i_tp + PTR_W'(1);
      end
    end else if (i_pop) begin
      if (w_empty) begin
        o_act = ACT_POP_EMPTY;
      end else begin
        o_act        = ACT_POP;
        o_tp_next    = i_tp - PTR_W'(1);
        o_count_next = i_count - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/param_stack.sv
// Parametrised call/return and data stack with registered top-of-stack,
// atomic replace, saturate/circular overflow policy and sticky error flags.
module param_stack
  import cpu_pkg::*;
#(
  parameter int DATA_W    = CPU_DATA_W,
  parameter int DEPTH     = 8,
  parameter int WRAP_MODE = 0,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_tp;
  logic [PTR_W:0]    r_count;
  logic [DATA_W-1:0] r_dout;
  logic              r_ovf;
  logic              r_unf;

  stk_act_e          w_act;
  logic [PTR_W-1:0]  w_tp_next;
  logic [PTR_W:0]    w_count_next;
  logic              w_we;
  logic [PTR_W-1:0]  w_waddr;
  logic [PTR_W-1:0]  w_raddr;
  logic              w_deep;

  stack_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .WRAP_MODE (WRAP_MODE),
    .PTR_W     (PTR_W)
  ) u_ptr (
    .i_tp         (r_tp),
    .i_count      (r_count),
    .i_push       (push),
    .i_pop        (pop),
    .o_act        (w_act),
    .o_tp_next    (w_tp_next),
    .o_count_next (w_count_next)
  );

  assign w_we    = (w_act == ACT_PUSH) || (w_act == ACT_REPLACE) ||
                   ((w_act == ACT_PUSH_FULL) && (WRAP_MODE != 0));
  assign w_waddr = (w_act == ACT_REPLACE) ? (r_tp - PTR_W'(1)) : r_tp;
  assign w_raddr = r_tp - PTR_W'(2);
  assign w_deep  = (r_count >= (PTR_W+1)'(2));

  // Storage carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (!reset && w_we) r_mem[w_waddr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tp    <= '0;
      r_count <= '0;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_tp    <= w_tp_next;
      r_count <= w_count_next;
      r_ovf   <= (w_act == ACT_PUSH_FULL) | (r_ovf & ~clr_err);
      r_unf   <= (w_act == ACT_POP_EMPTY) | (r_unf & ~clr_err);
      // New top comes straight from din on writes, so no write-through path is needed
      case (w_act)
        ACT_PUSH, ACT_REPLACE: r_dout <= din;
        ACT_PUSH_FULL: if (WRAP_MODE != 0) r_dout <= din;
        ACT_POP:       r_dout <= w_deep ? r_mem[w_raddr] : '0;
        default: ;
      endcase
    end
  end

  assign dout      = r_dout;
  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_FULL);
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule
